// File: rtl/sync_down_counter.sv
// Loadable WIDTH-bit down-counter with a registered one-cycle terminal-count pulse.
// Define SYNC_DOWN_COUNTER_AUTORELOAD_EN to reload from the last load value at expiry (divide-by-N).
//
// state | meaning
// IDLE  | never loaded, or loaded with zero
// RUN   | counting down while en is high
// DONE  | expired, holding zero until load or rst
module sync_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q;
   logic [WIDTH-1:0] out_q;
   logic             tc_q;
   logic             busy_q;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         out_q    <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
         reload_q <= '0;
`endif
      end else if (load) begin
         out_q <= load_val;
         tc_q  <= 1'b0;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
         reload_q <= load_val;
`endif
         if (load_val != '0) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
         end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end
      end else begin
         tc_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (en) begin
                  if (out_q > ONE) begin
                     out_q <= out_q - ONE;
                  end else begin
                     // out_q is 1 here: RUN is only entered with a nonzero value
                     tc_q <= 1'b1;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
                     out_q <= reload_q;
`else
                     out_q   <= '0;
                     state_q <= DONE;
                     busy_q  <= 1'b0;
`endif
                  end
               end
            end
            default: begin
               // IDLE and DONE hold the count and ignore en
            end
         endcase
      end
   end

   assign out  = out_q;
   assign tc   = tc_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter (WIDTH=4).
module tb_sync_down_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [3:0] load_val;
   logic       en;
   logic [3:0] out_w;
   logic       tc_w;
   logic       busy_w;

   int n_total = 0;
   int n_pass  = 0;

   sync_down_counter #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .out      (out_w),
      .tc       (tc_w),
      .busy     (busy_w)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_total++;
         if (out_w !== 4'd0 || tc_w !== 1'b0 || busy_w !== 1'b0)
            $display("FAIL reset_hold cyc%0d: out=%0d tc=%b busy=%b, want out=0 tc=0 busy=0", i, out_w, tc_w, busy_w);
         else n_pass++;
      end
      rst = 1'b0; load = 1'b0;
      tick();
      n_total++;
      if (out_w !== 4'd0 || tc_w !== 1'b0 || busy_w !== 1'b0)
         $display("FAIL reset_release: out=%0d tc=%b busy=%b, want out=0 tc=0 busy=0", out_w, tc_w, busy_w);
      else n_pass++;
   endtask

   task automatic test_basic_count();
      logic [3:0] exp_seq [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      load = 1'b1; load_val = 4'd5; en = 1'b1;
      tick();
      load = 1'b0;
      n_total++;
      if (out_w !== 4'd5 || tc_w !== 1'b0 || busy_w !== 1'b1)
         $display("FAIL basic_load: out=%0d tc=%b busy=%b, want out=5 tc=0 busy=1", out_w, tc_w, busy_w);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_total++;
         if (out_w !== exp_seq[i] || tc_w !== (exp_seq[i] == 4'd0) || busy_w !== (exp_seq[i] != 4'd0))
            $display("FAIL basic_count step%0d: out=%0d tc=%b busy=%b, want out=%0d tc=%b busy=%b",
                     i, out_w, tc_w, busy_w, exp_seq[i], exp_seq[i] == 4'd0, exp_seq[i] != 4'd0);
         else n_pass++;
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_total++;
         if (out_w !== 4'd0 || tc_w !== 1'b0 || busy_w !== 1'b0)
            $display("FAIL done_hold cyc%0d: out=%0d tc=%b busy=%b, want out=0 tc=0 busy=0", i, out_w, tc_w, busy_w);
         else n_pass++;
      end
   endtask

   task automatic test_enable_gating();
      logic       en_pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] exp_seq [6] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
      load = 1'b1; load_val = 4'd4; en = 1'b0;
      tick();
      load = 1'b0;
      n_total++;
      if (out_w !== 4'd4 || busy_w !== 1'b1)
         $display("FAIL enable_load: out=%0d busy=%b, want out=4 busy=1", out_w, busy_w);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         en = en_pat[i];
         tick();
         n_total++;
         if (out_w !== exp_seq[i] || tc_w !== (i == 5))
            $display("FAIL enable_gate step%0d: out=%0d tc=%b, want out=%0d tc=%b", i, out_w, tc_w, exp_seq[i], i == 5);
         else n_pass++;
      end
      en = 1'b1;
      tick();
      n_total++;
      if (out_w !== 4'd0 || tc_w !== 1'b0)
         $display("FAIL tc_single: out=%0d tc=%b, want out=0 tc=0", out_w, tc_w);
      else n_pass++;
   endtask

   task automatic test_autoreload();
      load = 1'b1; load_val = 4'd3; en = 1'b1;
      tick();
      load = 1'b0;
      n_total++;
      if (out_w !== 4'd3 || busy_w !== 1'b1)
         $display("FAIL autoreload_load: out=%0d busy=%b, want out=3 busy=1", out_w, busy_w);
      else n_pass++;
      for (int i = 1; i <= 12; i++) begin
         logic [3:0] exp_out;
         exp_out = (i % 3 == 1) ? 4'd2 : (i % 3 == 2) ? 4'd1 : 4'd3;
         tick();
         n_total++;
         if (out_w !== exp_out || tc_w !== (i % 3 == 0) || busy_w !== 1'b1)
            $display("FAIL autoreload step%0d: out=%0d tc=%b busy=%b, want out=%0d tc=%b busy=1",
                     i, out_w, tc_w, busy_w, exp_out, i % 3 == 0);
         else n_pass++;
      end
   endtask

   task automatic test_reload_and_zero();
      load = 1'b1; load_val = 4'd5; en = 1'b1;
      tick();
      load = 1'b0;
      tick();
      tick();
      n_total++;
      if (out_w !== 4'd3)
         $display("FAIL pre_reload: out=%0d, want 3", out_w);
      else n_pass++;
      load = 1'b1; load_val = 4'd9;
      tick();
      n_total++;
      if (out_w !== 4'd9 || tc_w !== 1'b0 || busy_w !== 1'b1)
         $display("FAIL reload_mid: out=%0d tc=%b busy=%b, want out=9 tc=0 busy=1", out_w, tc_w, busy_w);
      else n_pass++;
      load_val = 4'd0;
      tick();
      load = 1'b0;
      n_total++;
      if (out_w !== 4'd0 || tc_w !== 1'b0 || busy_w !== 1'b0)
         $display("FAIL zero_load: out=%0d tc=%b busy=%b, want out=0 tc=0 busy=0", out_w, tc_w, busy_w);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_total++;
         if (out_w !== 4'd0 || tc_w !== 1'b0 || busy_w !== 1'b0)
            $display("FAIL zero_idle cyc%0d: out=%0d tc=%b busy=%b, want out=0 tc=0 busy=0", i, out_w, tc_w, busy_w);
         else n_pass++;
      end
   endtask

   task automatic test_collision_and_rst();
      load = 1'b1; load_val = 4'd2; en = 1'b1;
      tick();
      load = 1'b0;
      tick();
      n_total++;
      if (out_w !== 4'd1)
         $display("FAIL pre_collision: out=%0d, want 1", out_w);
      else n_pass++;
      load = 1'b1; load_val = 4'd11;
      tick();
      load = 1'b0;
      n_total++;
      if (out_w !== 4'd11 || tc_w !== 1'b0 || busy_w !== 1'b1)
         $display("FAIL collision: out=%0d tc=%b busy=%b, want out=11 tc=0 busy=1", out_w, tc_w, busy_w);
      else n_pass++;
      for (int i = 0; i < 5; i++) tick();
      n_total++;
      if (out_w !== 4'd6 || tc_w !== 1'b0)
         $display("FAIL post_collision: out=%0d tc=%b, want out=6 tc=0", out_w, tc_w);
      else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++;
      if (out_w !== 4'd0 || tc_w !== 1'b0 || busy_w !== 1'b0)
         $display("FAIL rst_midcount: out=%0d tc=%b busy=%b, want out=0 tc=0 busy=0", out_w, tc_w, busy_w);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_total++;
         if (out_w !== 4'd0 || tc_w !== 1'b0 || busy_w !== 1'b0)
            $display("FAIL idle_after_rst cyc%0d: out=%0d tc=%b busy=%b, want out=0 tc=0 busy=0", i, out_w, tc_w, busy_w);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load_val = 4'd0; en = 1'b0;
      #2;
      test_reset();
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
      test_autoreload();
`else
      test_basic_count();
      test_enable_gating();
`endif
      test_reload_and_zero();
      test_collision_and_rst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
